// File: rtl/dispatch_stage.sv
// In-order dispatch FIFO with register scoreboard and same-cycle wakeup bypass.
// Optional stall counter enabled by defining DISPATCH_STALL_COUNT_EN.
module dispatch_stage #(
    parameter int DEPTH    = 4,
    parameter int NUM_REGS = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [6:0]                 in_opcode,
    input  logic [4:0]                 in_src1_addr,
    input  logic [4:0]                 in_src2_addr,
    input  logic [4:0]                 in_dest_addr,
    input  logic                       iq_full,
    output logic                       valid,
    output logic [6:0]                 opcode,
    output logic [4:0]                 src1_addr,
    output logic [4:0]                 src2_addr,
    output logic [4:0]                 dest_addr,
    output logic                       src1_ready,
    output logic                       src2_ready,
    input  logic                       wakeup_valid,
    input  logic [4:0]                 wakeup_dest,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [31:0]                stall_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Entry layout: {opcode[6:0], src1[4:0], src2[4:0], dest[4:0]}
    logic [21:0]         entry_mem_r [DEPTH];
    logic [PW-1:0]       wr_ptr_r;
    logic [PW-1:0]       rd_ptr_r;
    logic [NUM_REGS-1:0] busy_r;
    logic [NUM_REGS-1:0] busy_nxt_s;
    logic                empty_s;
    logic                full_s;
    logic                push_s;
    logic                pop_s;
    logic [21:0]         head_s;

    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign full_s    = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign in_ready  = !full_s && !flush;
    assign valid     = !empty_s && !flush;
    assign push_s    = in_valid && in_ready;
    assign pop_s     = valid && !iq_full;
    assign occupancy = wr_ptr_r - rd_ptr_r;

    assign head_s    = entry_mem_r[rd_ptr_r[AW-1:0]];
    assign opcode    = head_s[21:15];
    assign src1_addr = head_s[14:10];
    assign src2_addr = head_s[9:5];
    assign dest_addr = head_s[4:0];

    // Busy is read before this cycle's set, so the head never waits on its own dest.
    assign src1_ready = (src1_addr == 5'd0) || !busy_r[src1_addr] ||
                        (wakeup_valid && (wakeup_dest == src1_addr));
    assign src2_ready = (src2_addr == 5'd0) || !busy_r[src2_addr] ||
                        (wakeup_valid && (wakeup_dest == src2_addr));

    // Scoreboard next state: a set from a dispatching producer overrides a same-register wakeup.
    always_comb begin
        busy_nxt_s = busy_r;
        if (flush) begin
            busy_nxt_s = {NUM_REGS{1'b0}};
        end else begin
            if (wakeup_valid) begin
                busy_nxt_s[wakeup_dest] = 1'b0;
            end else begin
                busy_nxt_s = busy_nxt_s;
            end
            if (pop_s && (dest_addr != 5'd0)) begin
                busy_nxt_s[dest_addr] = 1'b1;
            end else begin
                busy_nxt_s = busy_nxt_s;
            end
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= {NUM_REGS{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // FIFO pointers; flush discards every entry.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Entry storage; cleared on reset so the head slot presents register 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_mem_r[i] <= 22'd0;
            end
        end else if (push_s) begin
            entry_mem_r[wr_ptr_r[AW-1:0]] <= {in_opcode, in_src1_addr, in_src2_addr, in_dest_addr};
        end
    end

`ifdef DISPATCH_STALL_COUNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles where the head is blocked by the issue queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= 32'd0;
        end else if (valid && iq_full && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign stall_count = stall_cnt_r;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_dispatch_stage.sv
// Directed self-checking bench for dispatch_stage (DEPTH=4, NUM_REGS=32).
module tb_dispatch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_src1_addr, in_src2_addr, in_dest_addr;
    logic        iq_full;
    logic        valid;
    logic [6:0]  opcode;
    logic [4:0]  src1_addr, src2_addr, dest_addr;
    logic        src1_ready, src2_ready;
    logic        wakeup_valid;
    logic [4:0]  wakeup_dest;
    logic        flush;
    logic [2:0]  occupancy;
    logic [31:0] stall_count;

    int checks = 0;
    int failures = 0;

    dispatch_stage #(.DEPTH(4), .NUM_REGS(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_src1_addr(in_src1_addr), .in_src2_addr(in_src2_addr), .in_dest_addr(in_dest_addr),
        .iq_full(iq_full), .valid(valid), .opcode(opcode),
        .src1_addr(src1_addr), .src2_addr(src2_addr), .dest_addr(dest_addr),
        .src1_ready(src1_ready), .src2_ready(src2_ready),
        .wakeup_valid(wakeup_valid), .wakeup_dest(wakeup_dest), .flush(flush),
        .occupancy(occupancy), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [4:0] d);
        in_valid     = v;
        in_opcode    = op;
        in_src1_addr = s1;
        in_src2_addr = s2;
        in_dest_addr = d;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_stall;
        reset = 1'b1; in_valid = 1'b0; in_opcode = 7'd0; in_src1_addr = 5'd0;
        in_src2_addr = 5'd0; in_dest_addr = 5'd0; iq_full = 1'b0;
        wakeup_valid = 1'b0; wakeup_dest = 5'd0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_valid", valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_occ", occupancy, 0);
        check("rst_s1r", src1_ready, 1);
        check("rst_s2r", src2_ready, 1);
        check("rst_opcode", opcode, 0);
        check("rst_dest", dest_addr, 0);
        check("rst_stall", stall_count, 0);

        // In-order dispatch with back-to-back dependency on r3
        drive(1'b1, 7'h33, 5'd1, 5'd2, 5'd3);
        tick();
        drive(1'b1, 7'h13, 5'd3, 5'd0, 5'd4);
        check("d1_valid", valid, 1);
        check("d1_opcode", opcode, 32'h33);
        check("d1_s1r", src1_ready, 1);
        check("d1_s2r", src2_ready, 1);
        check("d1_dest", dest_addr, 3);
        check("d1_occ", occupancy, 1);
        tick();
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        check("d2_valid", valid, 1);
        check("d2_opcode", opcode, 32'h13);
        check("d2_s1r", src1_ready, 0);
        check("d2_s2r", src2_ready, 1);
        tick();
        check("d_empty", valid, 0);

        // Same-cycle wakeup bypass on r5
        drive(1'b1, 7'h01, 5'd0, 5'd0, 5'd5);
        tick();
        drive(1'b1, 7'h02, 5'd5, 5'd0, 5'd0);
        tick();
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        iq_full = 1'b1; #1;
        check("wk_opcode", opcode, 32'h02);
        check("wk_s1r_busy", src1_ready, 0);
        wakeup_valid = 1'b1; wakeup_dest = 5'd5; #1;
        check("wk_s1r_bypass", src1_ready, 1);
        tick();
        wakeup_valid = 1'b0; #1;
        check("wk_s1r_cleared", src1_ready, 1);
        iq_full = 1'b0;
        tick();

        // Set/clear collision on r7: the set wins
        drive(1'b1, 7'h03, 5'd0, 5'd0, 5'd7);
        tick();
        drive(1'b1, 7'h04, 5'd7, 5'd0, 5'd0);
        wakeup_valid = 1'b1; wakeup_dest = 5'd7; #1;
        tick();
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        wakeup_valid = 1'b0; #1;
        check("col_opcode", opcode, 32'h04);
        check("col_s1r", src1_ready, 0);
        tick();

        // Flush mid-stream with r3, r4 busy
        iq_full = 1'b1;
        drive(1'b1, 7'h10, 5'd3, 5'd0, 5'd0);
        tick();
        drive(1'b1, 7'h11, 5'd4, 5'd0, 5'd0);
        check("fl_pre_s1r", src1_ready, 0);
        tick();
        drive(1'b1, 7'h12, 5'd0, 5'd0, 5'd0);
        tick();
        flush = 1'b1;
        drive(1'b1, 7'h13, 5'd0, 5'd0, 5'd0);
        check("fl_in_ready", in_ready, 0);
        check("fl_valid", valid, 0);
        check("fl_occ_pre", occupancy, 3);
        tick();
        flush = 1'b0;
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        check("fl_valid_post", valid, 0);
        check("fl_occ_post", occupancy, 0);
        drive(1'b1, 7'h20, 5'd3, 5'd4, 5'd0);
        tick();
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        check("fl_opcode", opcode, 32'h20);
        check("fl_occ_one", occupancy, 1);
        check("fl_s1r", src1_ready, 1);
        check("fl_s2r", src2_ready, 1);
        iq_full = 1'b0;
        tick();

        // Register 0 is never busy
        drive(1'b1, 7'h30, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b1, 7'h31, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        check("r0_opcode", opcode, 32'h31);
        check("r0_s1r", src1_ready, 1);
        check("r0_s2r", src2_ready, 1);
        tick();

        // Reset clears stall_count before the full/backpressure run
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        check("rst2_stall", stall_count, 0);
        check("rst2_valid", valid, 0);

        iq_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 7'h40 + 7'(i), 5'(i), 5'd0, 5'd0);
            check("full_occ", occupancy, 32'(i));
            check("full_in_ready", in_ready, (i < 4) ? 32'd1 : 32'd0);
            tick();
        end
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        iq_full = 1'b0; #1;
`ifdef DISPATCH_STALL_COUNT_EN
        exp_stall = 32'd4;
`else
        exp_stall = 32'd0;
`endif
        check("full_occ4", occupancy, 4);
        check("full_in_ready4", in_ready, 0);
        check("full_stall", stall_count, exp_stall);
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", valid, 1);
            check("drain_opcode", opcode, 32'h40 + 32'(i));
            tick();
        end
        check("drain_empty", valid, 0);
        check("drain_occ", occupancy, 0);

        // Second lap exercises pointer wrap
        iq_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 7'h50 + 7'(i), 5'd0, 5'd0, 5'd0);
            tick();
        end
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        iq_full = 1'b0; #1;
`ifdef DISPATCH_STALL_COUNT_EN
        exp_stall = 32'd7;
`else
        exp_stall = 32'd0;
`endif
        check("wrap_occ", occupancy, 4);
        check("wrap_in_ready", in_ready, 0);
        check("wrap_stall", stall_count, exp_stall);
        for (int i = 0; i < 4; i++) begin
            check("wrap_opcode", opcode, 32'h50 + 32'(i));
            tick();
        end
        check("wrap_empty", valid, 0);
        check("wrap_stall_hold", stall_count, exp_stall);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dispatch_stage.md
# dispatch_stage

In-order dispatch buffer between decode and `issue_queue`. Holds up to DEPTH decoded instructions in a FIFO and tracks per-architectural-register busy bits in a scoreboard. For the head instruction it computes `src1_ready`/`src2_ready`, then hands the instruction to the issue queue under backpressure. Wakeup broadcasts from execution clear busy bits and are bypassed into the ready computation in the same cycle.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `NUM_REGS`, 32, architectural registers; index width fixed at 5 bits
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  decode offers an instruction
- `in_ready`  out  1  buffer accepts; push = `in_valid && in_ready`
- `in_opcode`  in  7  opcode
- `in_src1_addr`, `in_src2_addr`, `in_dest_addr`  in  5 each  register indices
- `iq_full`  in  1  issue queue cannot accept this cycle
- `valid`  out  1  head instruction presented to the issue queue
- `opcode`  out  7  head opcode
- `src1_addr`, `src2_addr`, `dest_addr`  out  5 each  head register indices
- `src1_ready`, `src2_ready`  out  1 each  operand available at dispatch
- `wakeup_valid`  in  1  execution result broadcast
- `wakeup_dest`  in  5  register written by the broadcast
- `flush`  in  1  squash all buffered state
- `occupancy`  out  $clog2(DEPTH)+1  entries held
- `stall_count`  out  32  cycles with `valid && iq_full` (see Configuration)

## Operation
- **FIFO**
  - Read/write pointers carry an extra wrap bit.
  - Empty when pointers are equal. Full when indices are equal and wrap bits differ.
  - `in_ready = !full && !flush`. There is no push while full, even if a pop occurs in the same cycle.
- **Dispatch**
  - `valid = !empty && !flush`.
  - Pop = `valid && !iq_full`. The issue queue captures the outputs on that edge.
- **Scoreboard**
  - `busy[NUM_REGS]`; `busy[0]` is hardwired to 0.
  - On pop with `dest_addr != 0`: set `busy[dest_addr]`.
  - On `wakeup_valid`: clear `busy[wakeup_dest]`.
  - Same register set and cleared in the same cycle: the set wins, because the newer producer is outstanding.
- **Ready computation** (combinational, head entry), for `srcN` ∈ {src1, src2}:
  - `srcN_ready = (srcN_addr == 0) || !busy[srcN_addr] || (wakeup_valid && wakeup_dest == srcN_addr)`.
  - The head's own `dest_addr` does not affect its own sources, since busy is read before it is set.
- **Outputs when `valid = 0`**: `opcode`/addr outputs show the head slot contents. Only `valid` is meaningful.
- **Flush**
  - At the edge: pointers reset to 0 and all busy bits are cleared.
  - In the flush cycle: no push, no pop, and the wakeup is ignored.
- **Reset**: same effect as flush, plus `stall_count` is cleared. Reset applied mid-operation discards all entries.

## Timing
- Push-to-`valid` latency is 1 cycle. There is no fall-through: an entry pushed at edge N is visible after edge N.
- Throughput is 1 push and 1 pop per cycle when neither full nor empty.
- Ready outputs are combinational from head contents, scoreboard state, and the current-cycle wakeup.
- A scoreboard set on pop at edge N is visible to the next head after edge N. This catches back-to-back dependent instructions.
- Reset values:
  - `valid` = 0
  - `in_ready` = 1 when `flush` = 0
  - `occupancy` = 0
  - `src1_ready`/`src2_ready` = 1 (head slot reset to registers 0)
  - `opcode`/addr outputs = 0
  - `stall_count` = 0
  - all busy bits = 0
- Pointer wrap: index wraps modulo DEPTH and the wrap bit toggles. Occupancy = write pointer − read pointer, computed in ($clog2(DEPTH)+1) bits.

## Configuration
- `DISPATCH_STALL_COUNT_EN` defined:
  - `stall_count` increments each cycle where `valid && iq_full`.
  - Saturates at 0xFFFF_FFFF.
  - Cleared by reset only; not cleared by flush.
- Undefined: `stall_count` is tied to 0 and no counter register exists.

## Test plan
- **Reset, then in-order dispatch:** push {op=0x33, s1=1, s2=2, d=3} and {op=0x13, s1=3, s2=0, d=4} on consecutive cycles with `iq_full` = 0.
  - First dispatch has ready=1/1.
  - Second has `src1_ready` = 0 (r3 busy) and `src2_ready` = 1.
- **Same-cycle wakeup bypass:** hold a head with s1=5 where r5 is busy, assert `wakeup_valid` with `wakeup_dest` = 5.
  - `src1_ready` = 1 in that cycle.
  - `busy[5]` = 0 afterwards.
- **Set/clear collision:** pop d=7 in the same cycle as `wakeup_dest` = 7.
  - `busy[7]` = 1 afterwards; the next head with s1=7 shows ready=0.
- **Full/backpressure with DEPTH=4:** hold `iq_full` = 1 and push 5 instructions.
  - `in_ready` drops after 4; `occupancy` = 4.
  - `stall_count` increments each cycle (macro on) or stays 0 (macro off).
  - Release `iq_full`: 4 pops in order, and pointers wrap correctly on a further 4 pushes.
- **Flush mid-stream:** with 3 entries buffered and r3, r4 busy, pulse `flush`.
  - Next cycle: `valid` = 0, `occupancy` = 0, all busy bits = 0.
  - The flush-cycle `in_valid` is not accepted.
- **Register 0:** dispatch d=0, then s1=0.
  - `busy[0]` stays 0; `src1_ready` = 1.
